// File: rtl/ic_backup_ctrl.sv
// ic_backup_ctrl: checkpoints dirty pipeline slots to NVM on a power warning and restores them after reset
module ic_backup_ctrl #(
  parameter int NREG = 3,
  parameter int W = 32,
  localparam int AW = $clog2(NREG + 1)
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Pwr_warn,
  output logic               Stand_by,
  output logic               Bkp_done,
  input  logic [2*NREG-1:0]  Dirty_vals,
  output logic [NREG-1:0]    Backup_ens,
  output logic [NREG-1:0]    Backup_acks,
  input  logic [NREG*W-1:0]  Backup_Vouts,
  output logic [NREG-1:0]    Restore_ens,
  output logic [NREG*W-1:0]  Restore_Vins,
  output logic               Nvm_req,
  output logic               Nvm_we,
  output logic [AW-1:0]      Nvm_addr,
  output logic [W-1:0]       Nvm_wdata,
  input  logic [W-1:0]       Nvm_rdata,
  input  logic               Nvm_ready
);
  typedef enum logic [3:0] {R_CHK, R_RD, R_LOAD, IDLE, B_INV, B_SCAN, B_WR, B_ACK, B_COMMIT, HALT} state_t;
  state_t state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [W-1:0] hold, hold_n;
  logic [NREG-1:0] sel;
  logic gap, mem_st, hit, last, unused_dirty;
  assign sel = NREG'(1) << idx;
  assign last = idx == AW'(NREG - 1);
  assign mem_st = state inside {R_CHK, R_RD, B_INV, B_WR, B_COMMIT};
  // gap forces req low for one cycle after every accepted transfer; Rst gating keeps NVM outputs quiet in reset
  assign Nvm_req = Rst & mem_st & ~gap;
  assign hit = Nvm_req & Nvm_ready;
  assign Nvm_we = Nvm_req & (state inside {B_INV, B_WR, B_COMMIT});
  assign Nvm_addr = !Nvm_req ? '0 : (state inside {R_RD, B_WR}) ? idx : AW'(NREG);
  assign Nvm_wdata = !Nvm_req ? '0 : state == B_WR ? Backup_Vouts[W*idx +: W] : W'(state == B_COMMIT);
  assign Stand_by = state != IDLE;
  assign Bkp_done = state == HALT;
  assign Backup_ens = state == B_WR ? sel : '0;
  assign Backup_acks = state == B_ACK ? sel : '0;
  assign Restore_ens = state == R_LOAD ? sel : '0;
  assign Restore_Vins = state == R_LOAD ? {NREG{hold}} : '0;
  assign unused_dirty = ^Dirty_vals;
  // state, slot index, restore holding register and post-transfer gap flag
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= R_CHK;
      idx <= '0;
      hold <= '0;
      gap <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      hold <= hold_n;
      gap <= hit;
    end
  end
  // next-state sequencing of restore and backup walks
  always_comb begin
    state_n = state;
    idx_n = idx;
    hold_n = hold;
    case (state)
      R_CHK: if (hit) begin
        state_n = Nvm_rdata[0] ? R_RD : IDLE;
        idx_n = '0;
      end
      R_RD: if (hit) begin
        hold_n = Nvm_rdata;
        state_n = R_LOAD;
      end
      R_LOAD: begin
        state_n = last ? IDLE : R_RD;
        idx_n = last ? '0 : idx + AW'(1);
      end
      IDLE: state_n = Pwr_warn ? B_INV : IDLE;
      B_INV: if (hit) begin
        state_n = B_SCAN;
        idx_n = '0;
      end
      B_SCAN: begin
        state_n = Dirty_vals[2*idx+1] ? B_WR : last ? B_COMMIT : B_SCAN;
        idx_n = (Dirty_vals[2*idx+1] || last) ? idx : idx + AW'(1);
      end
      B_WR: state_n = hit ? B_ACK : B_WR;
      B_ACK: begin
        state_n = last ? B_COMMIT : B_SCAN;
        idx_n = last ? idx : idx + AW'(1);
      end
      B_COMMIT: state_n = hit ? HALT : B_COMMIT;
      HALT: state_n = HALT;
      default: state_n = R_CHK;
    endcase
  end
endmodule

// File: tb/tb_ic_backup_ctrl.sv
// tb_ic_backup_ctrl: scoreboard bench with an NVM model for ic_backup_ctrl
module tb_ic_backup_ctrl;
  localparam int NREG = 3, W = 32, AW = 2;
  logic Clk = 0, Rst = 0, Pwr_warn = 0, Nvm_ready = 0;
  logic Stand_by, Bkp_done, Nvm_req, Nvm_we;
  logic [2*NREG-1:0] Dirty_vals = '0;
  logic [NREG-1:0] Backup_ens, Backup_acks, Restore_ens;
  logic [NREG*W-1:0] Backup_Vouts, Restore_Vins;
  logic [AW-1:0] Nvm_addr;
  logic [W-1:0] Nvm_wdata, Nvm_rdata = '0;
  logic [W-1:0] mem [0:NREG];
  int lat = 1, cnt = 0, tests = 0, fails = 0;
  logic prev_req = 0, prev_hs = 0, prev_we = 0, hs;
  logic [AW-1:0] prev_addr = '0;
  logic [W-1:0] prev_wdata = '0;
  logic [NREG-1:0] prev_ens = '0;
  localparam logic [W-1:0] S0 = 32'h1111_00A0, S1 = 32'h2222_00B0, S2 = 32'h3333_00C0;
  typedef struct {logic we; logic [AW-1:0] addr; logic [W-1:0] wdata; logic [NREG-1:0] ens;} nvm_t;
  typedef struct {logic [NREG-1:0] ens; logic [W-1:0] data;} rst_t;
  nvm_t q_nvm[$];
  rst_t q_rst[$];
  logic [NREG-1:0] q_ack[$];
  assign Backup_Vouts = {S2, S1, S0};
  ic_backup_ctrl #(.NREG(NREG), .W(W)) dut (
    .Clk(Clk), .Rst(Rst), .Pwr_warn(Pwr_warn), .Stand_by(Stand_by), .Bkp_done(Bkp_done),
    .Dirty_vals(Dirty_vals), .Backup_ens(Backup_ens), .Backup_acks(Backup_acks),
    .Backup_Vouts(Backup_Vouts), .Restore_ens(Restore_ens), .Restore_Vins(Restore_Vins),
    .Nvm_req(Nvm_req), .Nvm_we(Nvm_we), .Nvm_addr(Nvm_addr), .Nvm_wdata(Nvm_wdata),
    .Nvm_rdata(Nvm_rdata), .Nvm_ready(Nvm_ready)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic exp_nvm(input logic we, input int a, input logic [W-1:0] d, input logic [NREG-1:0] e);
    nvm_t t;
    t.we = we; t.addr = AW'(a); t.wdata = d; t.ens = e;
    q_nvm.push_back(t);
  endtask
  task automatic exp_rst(input logic [NREG-1:0] e, input logic [W-1:0] d);
    rst_t r;
    r.ens = e; r.data = d;
    q_rst.push_back(r);
  endtask
  // NVM model plus monitor: handshakes, restore strobes and acks are popped against the queues
  always @(negedge Clk) begin
    nvm_t t;
    rst_t r;
    if (prev_hs) chk("req_drop", W'(Nvm_req), 0);
    if (Nvm_req && prev_req && !prev_hs) begin
      chk("hold_addr", W'(Nvm_addr), W'(prev_addr));
      chk("hold_wdata", Nvm_wdata, prev_wdata);
      chk("hold_we", W'(Nvm_we), W'(prev_we));
      chk("hold_bkp_ens", W'(Backup_ens), W'(prev_ens));
    end
    chk("strobe_excl", W'($countones(Backup_ens) + $countones(Backup_acks) + $countones(Restore_ens) <= 1), 1);
    hs = 0;
    if (Nvm_req) begin
      cnt++;
      if (cnt >= lat) begin
        Nvm_ready = 1;
        Nvm_rdata = mem[Nvm_addr];
        hs = 1;
        cnt = 0;
        if (q_nvm.size() == 0) begin
          tests++; fails++;
          $display("FAIL nvm_unexpected: got we=%0b addr=%0d wdata=%0h expected no transfer", Nvm_we, Nvm_addr, Nvm_wdata);
        end else begin
          t = q_nvm.pop_front();
          chk("nvm_we", W'(Nvm_we), W'(t.we));
          chk("nvm_addr", W'(Nvm_addr), W'(t.addr));
          chk("nvm_wdata", t.we ? Nvm_wdata : '0, t.we ? t.wdata : '0);
          chk("nvm_bkp_ens", W'(Backup_ens), W'(t.ens));
        end
        if (Nvm_we) mem[Nvm_addr] = Nvm_wdata;
      end else Nvm_ready = 0;
    end else begin
      Nvm_ready = 0;
      cnt = 0;
    end
    if (Restore_ens != 0) begin
      if (q_rst.size() == 0) begin
        tests++; fails++;
        $display("FAIL restore_unexpected: got ens=%b expected none", Restore_ens);
      end else begin
        r = q_rst.pop_front();
        chk("restore_ens", W'(Restore_ens), W'(r.ens));
        for (int i = 0; i < NREG; i++) chk("restore_vins", Restore_Vins[W*i +: W], r.data);
      end
    end
    if (Backup_acks != 0) begin
      if (q_ack.size() == 0) begin
        tests++; fails++;
        $display("FAIL ack_unexpected: got acks=%b expected none", Backup_acks);
      end else chk("backup_acks", W'(Backup_acks), W'(q_ack.pop_front()));
    end
    prev_req = Nvm_req; prev_hs = hs; prev_we = Nvm_we;
    prev_addr = Nvm_addr; prev_wdata = Nvm_wdata; prev_ens = Backup_ens;
  end
  task automatic tick();
    @(posedge Clk); #1;
  endtask
  task automatic wait_for(input string name, input int sel, input int bound);
    logic ok;
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      ok = sel == 0 ? !Stand_by : sel == 1 ? Bkp_done : (Backup_ens != 0);
    end
    chk(name, W'(ok), 1);
  endtask
  task automatic do_reset();
    Rst = 0;
    #1;
    chk("rst_stand_by", W'(Stand_by), 1);
    chk("rst_outs", W'({Bkp_done, Nvm_req, Nvm_we, Nvm_addr, Backup_ens, Backup_acks, Restore_ens}), 0);
    chk("rst_nvm_wdata", Nvm_wdata, 0);
    chk("rst_vins", W'(|Restore_Vins), 0);
    tick();
    tick();
    Rst = 1;
  endtask
  task automatic queues_empty(input string name);
    chk({name, "_nvm_left"}, W'(q_nvm.size()), 0);
    chk({name, "_rst_left"}, W'(q_rst.size()), 0);
    chk({name, "_ack_left"}, W'(q_ack.size()), 0);
  endtask
  initial begin
    mem[0] = 32'hA1; mem[1] = 32'hB2; mem[2] = 32'hC3; mem[3] = 0;
    tick();
    exp_nvm(0, 3, 0, 0);
    do_reset();
    wait_for("empty_restore_idle", 0, 20);
    repeat (2) tick();
    chk("idle_stand_by", W'(Stand_by), 0);
    queues_empty("s1");
    mem[3] = 1;
    exp_nvm(0, 3, 0, 0); exp_nvm(0, 0, 0, 0); exp_nvm(0, 1, 0, 0); exp_nvm(0, 2, 0, 0);
    exp_rst(3'b001, 32'hA1); exp_rst(3'b010, 32'hB2); exp_rst(3'b100, 32'hC3);
    do_reset();
    wait_for("restore_idle", 0, 50);
    queues_empty("s2");
    exp_nvm(1, 3, 0, 0); exp_nvm(1, 0, S0, 3'b001); exp_nvm(1, 2, S2, 3'b100); exp_nvm(1, 3, 1, 0);
    q_ack.push_back(3'b001); q_ack.push_back(3'b100);
    Dirty_vals = 6'b10_00_10;
    Pwr_warn = 1;
    wait_for("backup_done", 1, 100);
    chk("halt_stand_by", W'(Stand_by), 1);
    Pwr_warn = 0;
    repeat (5) tick();
    chk("halt_sticky", W'(Bkp_done), 1);
    chk("commit_word", mem[3], 1);
    queues_empty("s3");
    exp_nvm(0, 3, 0, 0); exp_nvm(0, 0, 0, 0); exp_nvm(0, 1, 0, 0); exp_nvm(0, 2, 0, 0);
    exp_rst(3'b001, S0); exp_rst(3'b010, 32'hB2); exp_rst(3'b100, S2);
    do_reset();
    wait_for("restore2_idle", 0, 50);
    exp_nvm(1, 3, 0, 0); exp_nvm(1, 3, 1, 0);
    Dirty_vals = 6'b01_01_01;
    Pwr_warn = 1;
    wait_for("clean_backup_done", 1, 50);
    Pwr_warn = 0;
    queues_empty("s4");
    mem[3] = 0;
    exp_nvm(0, 3, 0, 0);
    do_reset();
    wait_for("s5_idle", 0, 20);
    lat = 6;
    exp_nvm(1, 3, 0, 0); exp_nvm(1, 1, S1, 3'b010); exp_nvm(1, 3, 1, 0);
    q_ack.push_back(3'b010);
    Dirty_vals = 6'b00_10_00;
    Pwr_warn = 1;
    wait_for("slow_wr_start", 2, 60);
    repeat (2) tick();
    Pwr_warn = 0;
    wait_for("slow_backup_done", 1, 100);
    queues_empty("s5");
    lat = 1;
    mem[3] = 0;
    exp_nvm(0, 3, 0, 0);
    do_reset();
    wait_for("s6_idle", 0, 20);
    lat = 6;
    exp_nvm(1, 3, 0, 0);
    Dirty_vals = 6'b00_00_10;
    Pwr_warn = 1;
    wait_for("abort_wr_start", 2, 60);
    tick();
    Rst = 0;
    #1;
    chk("abort_req", W'(Nvm_req), 0);
    chk("abort_bkp_ens", W'(Backup_ens), 0);
    chk("abort_stand_by", W'(Stand_by), 1);
    chk("abort_done", W'(Bkp_done), 0);
    chk("abort_commit_invalid", mem[3], 0);
    Pwr_warn = 0;
    lat = 1;
    exp_nvm(0, 3, 0, 0);
    tick();
    Rst = 1;
    wait_for("abort_idle", 0, 20);
    repeat (2) tick();
    queues_empty("s6");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end
endmodule

// File: doc/ic_backup_ctrl.md
IC_BACKUP_CTRL -- requirements
Module: ic_backup_ctrl

Interface
REQ-001 SHALL have parameter NREG, 3, number of checkpointed pipeline registers (slots).
REQ-002 SHALL have parameter W, 32, slot data width; AW = clog2(NREG+1).
REQ-003 SHALL have port Clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Pwr_warn  in  1  power-failure warning, level.
REQ-006 SHALL have port Stand_by  out  1  freezes the pipeline while high.
REQ-007 SHALL have port Bkp_done  out  1  checkpoint committed; safe to power off.
REQ-008 SHALL have port Dirty_vals  in  2*NREG  per-slot code; bit 2i+1 = slot i dirty.
REQ-009 SHALL have ports Backup_ens / Backup_acks  out  NREG each  per-slot backup enable and one-cycle completion acknowledge.
REQ-010 SHALL have port Backup_Vouts  in  NREG*W  slot i data in bits [W*i +: W].
REQ-011 SHALL have ports Restore_ens  out  NREG, and Restore_Vins  out  NREG*W  restore load strobe and data.
REQ-012 SHALL have NVM ports Nvm_req, Nvm_we  out  1; Nvm_addr  out  AW; Nvm_wdata  out  W; Nvm_rdata  in  W; Nvm_ready  in  1.

Function
REQ-013 SHALL implement FSM states R_CHK, R_RD, R_LOAD, IDLE, B_INV, B_SCAN, B_WR, B_ACK, B_COMMIT, HALT; slot index idx counts 0..NREG-1.
REQ-014 NVM handshake: Nvm_req, Nvm_we, Nvm_addr and Nvm_wdata SHALL be held stable from request until the cycle Nvm_ready=1 is sampled, and req SHALL drop the following cycle; Nvm_ready is ignored while req=0; Nvm_rdata is valid in the ready cycle.
REQ-015 NVM address NREG holds the commit word (bit0=1: valid image); addresses 0..NREG-1 hold slot images.
REQ-016 R_CHK: read address NREG; on ready, go to R_RD with idx=0 if rdata[0]=1, else go to IDLE.
REQ-017 R_RD: read address idx; on ready, capture rdata into a W-bit holding register and go to R_LOAD.
REQ-018 R_LOAD: for exactly one cycle, Restore_ens = one-hot(idx) and the holding register drives every Restore_Vins slice; then go to R_RD with idx+1, or to IDLE after slot NREG-1.
REQ-019 IDLE: Stand_by=0; Pwr_warn=1 SHALL move to B_INV next cycle; Pwr_warn is not sampled in any other state.
REQ-020 B_INV: write 0 to address NREG; on ready, go to B_SCAN with idx=0.
REQ-021 B_SCAN: one cycle per slot; if dirty bit of idx is set, go to B_WR; else advance idx, or go to B_COMMIT after slot NREG-1.
REQ-022 B_WR: hold Backup_ens = one-hot(idx) and write Backup_Vouts slice idx to address idx; on ready, go to B_ACK.
REQ-023 B_ACK: Backup_acks = one-hot(idx) for one cycle; then advance idx, or go to B_COMMIT after slot NREG-1.
REQ-024 B_COMMIT: write 1 to address NREG; on ready, go to HALT.
REQ-025 HALT: Stand_by=1, Bkp_done=1; terminal until reset; Pwr_warn deassertion SHALL NOT exit.
REQ-026 Stand_by SHALL be 1 in every state except IDLE.
REQ-027 Backup_ens, Backup_acks and Restore_ens SHALL be at most one-hot and never asserted together.
REQ-028 Pwr_warn deassertion during backup SHALL NOT abort the backup; Pwr_warn asserted during restore takes effect in the first IDLE cycle.

Reset
REQ-029 While Rst=0: state R_CHK, idx=0, Stand_by=1, and all other outputs 0, including Restore_Vins.
REQ-030 Reset mid-operation SHALL abandon the transaction immediately; an uncommitted image stays invalid because commit=0 was written in B_INV.
REQ-031 The first NVM request SHALL be issued in the first cycle after Rst rises.

Verification
REQ-032 Release reset with NVM[3]=0 (ready at 1 cycle): one read of addr 3, no Restore_ens, Stand_by=0 from the following cycle.
REQ-033 NVM[3]=1, NVM[0..2]=A1,B2,C3: reads of addr 3,0,1,2; Restore_ens pulses 001,010,100 with Restore_Vins slice = A1,B2,C3 respectively; then IDLE.
REQ-034 IDLE, Dirty_vals=6'b10_00_10, Pwr_warn=1: writes (3,0),(0,slot0),(2,slot2),(3,1); Backup_acks pulses 001 then 100; Bkp_done=1, Stand_by=1.
REQ-035 No slot dirty, Pwr_warn=1: only writes (3,0) and (3,1); no Backup_ens/Backup_acks; HALT.
REQ-036 Nvm_ready delayed 5 cycles in B_WR, and Pwr_warn dropped mid-wait: req/addr/wdata and Backup_ens stay stable all 5 cycles; backup completes.
REQ-037 Reset asserted during B_WR, then released: outputs reset asynchronously; restore finds commit=0 and performs no restore.
